// File: rtl/alu_rs.sv
// Reservation station for integer/branch ops in front of the ALU.
// Wakes pending operands from both CDBs and dispatches the lowest-index ready entry.
module alu_rs #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4,
  parameter int ROB_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             issue_en,
  input  logic [5:0]       issue_op,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [ROB_W-1:0] issue_rob,
  input  logic             cdb_alu_en,
  input  logic [ROB_W-1:0] cdb_alu_rob,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_lsb_en,
  input  logic [ROB_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_lsb_val,
  output logic             rs_full,
  output logic             alu_flag,
  output logic [5:0]       alu_op,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [ROB_W-1:0] alu_rob
);

  logic [RS_SIZE-1:0] ent_vld;
  logic [RS_SIZE-1:0] ent_qj_busy;
  logic [RS_SIZE-1:0] ent_qk_busy;
  logic [5:0]         ent_op  [RS_SIZE];
  logic [31:0]        ent_vj  [RS_SIZE];
  logic [31:0]        ent_vk  [RS_SIZE];
  logic [ROB_W-1:0]   ent_qj  [RS_SIZE];
  logic [ROB_W-1:0]   ent_qk  [RS_SIZE];
  logic [ROB_W-1:0]   ent_rob [RS_SIZE];

  logic [RS_SIZE-1:0]  ent_rdy;
  logic                free_found;
  logic [RS_IDX_W-1:0] free_idx;
  logic                disp_found;
  logic [RS_IDX_W-1:0] disp_idx;
  logic [31:0]         iss_vj;
  logic [31:0]         iss_vk;
  logic                iss_qj_busy;
  logic                iss_qk_busy;
  logic                step;

  function automatic logic tag_hit(input logic en, input logic [ROB_W-1:0] bus_tag,
                                   input logic [ROB_W-1:0] want);
    return en && (bus_tag == want);
  endfunction

  assign ent_rdy = ent_vld & ~ent_qj_busy & ~ent_qk_busy;
  assign rs_full = &ent_vld;
  assign step    = rdy_in && !clear;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
      if (ent_rdy[i]) begin
        disp_found = 1'b1;
        disp_idx   = RS_IDX_W'(i);
      end
    end
  end

  // issue-time bypass: a producer broadcasting this cycle resolves the operand immediately
  always_comb begin
    iss_vj      = issue_vj;
    iss_vk      = issue_vk;
    iss_qj_busy = issue_qj_busy;
    iss_qk_busy = issue_qk_busy;
    if (issue_qj_busy) begin
      if (tag_hit(cdb_alu_en, cdb_alu_rob, issue_qj)) begin
        iss_vj      = cdb_alu_val;
        iss_qj_busy = 1'b0;
      end else if (tag_hit(cdb_lsb_en, cdb_lsb_rob, issue_qj)) begin
        iss_vj      = cdb_lsb_val;
        iss_qj_busy = 1'b0;
      end
    end
    if (issue_qk_busy) begin
      if (tag_hit(cdb_alu_en, cdb_alu_rob, issue_qk)) begin
        iss_vk      = cdb_alu_val;
        iss_qk_busy = 1'b0;
      end else if (tag_hit(cdb_lsb_en, cdb_lsb_rob, issue_qk)) begin
        iss_vk      = cdb_lsb_val;
        iss_qk_busy = 1'b0;
      end
    end
  end

  // ---- control and dispatch register stage ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ent_vld  <= '0;
      alu_flag <= 1'b0;
      alu_op   <= '0;
      alu_val1 <= '0;
      alu_val2 <= '0;
      alu_rob  <= '0;
    end else if (clear) begin
      ent_vld  <= '0;
      alu_flag <= 1'b0;
    end else if (!rdy_in) begin
      alu_flag <= 1'b0;
    end else begin
      alu_flag <= disp_found;
      if (disp_found) begin
        alu_op            <= ent_op[disp_idx];
        alu_val1          <= ent_vj[disp_idx];
        alu_val2          <= ent_vk[disp_idx];
        alu_rob           <= ent_rob[disp_idx];
        ent_vld[disp_idx] <= 1'b0;
      end
      if (issue_en && free_found) begin
        ent_vld[free_idx] <= 1'b1;
      end
    end
  end

  // ---- entry payload stage: wakeup and issue write ----
  always_ff @(posedge clk_in) begin
    if (step) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_vld[i] && ent_qj_busy[i]) begin
          if (tag_hit(cdb_alu_en, cdb_alu_rob, ent_qj[i])) begin
            ent_vj[i]      <= cdb_alu_val;
            ent_qj_busy[i] <= 1'b0;
          end else if (tag_hit(cdb_lsb_en, cdb_lsb_rob, ent_qj[i])) begin
            ent_vj[i]      <= cdb_lsb_val;
            ent_qj_busy[i] <= 1'b0;
          end
        end
        if (ent_vld[i] && ent_qk_busy[i]) begin
          if (tag_hit(cdb_alu_en, cdb_alu_rob, ent_qk[i])) begin
            ent_vk[i]      <= cdb_alu_val;
            ent_qk_busy[i] <= 1'b0;
          end else if (tag_hit(cdb_lsb_en, cdb_lsb_rob, ent_qk[i])) begin
            ent_vk[i]      <= cdb_lsb_val;
            ent_qk_busy[i] <= 1'b0;
          end
        end
      end
      if (issue_en && free_found) begin
        ent_op[free_idx]      <= issue_op;
        ent_rob[free_idx]     <= issue_rob;
        ent_qj[free_idx]      <= issue_qj;
        ent_qk[free_idx]      <= issue_qk;
        ent_vj[free_idx]      <= iss_vj;
        ent_vk[free_idx]      <= iss_vk;
        ent_qj_busy[free_idx] <= iss_qj_busy;
        ent_qk_busy[free_idx] <= iss_qk_busy;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, issue_en;
  logic [5:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic        issue_qj_busy, issue_qk_busy;
  logic [3:0]  issue_qj, issue_qk, issue_rob;
  logic        cdb_alu_en, cdb_lsb_en;
  logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
  logic [31:0] cdb_alu_val, cdb_lsb_val;
  logic        rs_full, alu_flag;
  logic [5:0]  alu_op;
  logic [31:0] alu_val1, alu_val2;
  logic [3:0]  alu_rob;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd5;

  alu_rs #(.RS_SIZE(16), .RS_IDX_W(4), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_en(issue_en), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rob(issue_rob),
    .cdb_alu_en(cdb_alu_en), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_en(cdb_lsb_en), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_val(cdb_lsb_val),
    .rs_full(rs_full), .alu_flag(alu_flag), .alu_op(alu_op),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_rob(alu_rob)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: a table of slots, each either empty or holding an op with resolved/pending operands.
  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [31:0] vj, vk;
    bit          jb, kb;
    logic [3:0]  qj, qk, rob;
  } ent_t;

  ent_t        m [16];
  logic        e_flag;
  logic [5:0]  e_op;
  logic [31:0] e_v1, e_v2;
  logic [3:0]  e_rob;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i].v = 0;
    e_flag = 0; e_op = 0; e_v1 = 0; e_v2 = 0; e_rob = 0;
  endtask

  function automatic bit model_full();
    for (int i = 0; i < 16; i++) if (!m[i].v) return 0;
    return 1;
  endfunction

  function automatic bit cdb_lookup(input logic [3:0] tag, output logic [31:0] val);
    val = 32'h0;
    if (cdb_alu_en && cdb_alu_rob == tag) begin val = cdb_alu_val; return 1; end
    if (cdb_lsb_en && cdb_lsb_rob == tag) begin val = cdb_lsb_val; return 1; end
    return 0;
  endfunction

  task automatic model_edge();
    ent_t nxt [16];
    int d, f;
    logic [31:0] bv;
    if (clear) begin
      for (int i = 0; i < 16; i++) m[i].v = 0;
      e_flag = 0;
      return;
    end
    if (!rdy_in) begin
      e_flag = 0;
      return;
    end
    nxt = m;
    d = -1; f = -1;
    for (int i = 0; i < 16; i++) begin
      if (d < 0 && m[i].v && !m[i].jb && !m[i].kb) d = i;
      if (f < 0 && !m[i].v) f = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i].v && m[i].jb && cdb_lookup(m[i].qj, bv)) begin nxt[i].vj = bv; nxt[i].jb = 0; end
      if (m[i].v && m[i].kb && cdb_lookup(m[i].qk, bv)) begin nxt[i].vk = bv; nxt[i].kb = 0; end
    end
    if (d >= 0) begin
      e_flag = 1; e_op = m[d].op; e_v1 = m[d].vj; e_v2 = m[d].vk; e_rob = m[d].rob;
      nxt[d].v = 0;
    end else begin
      e_flag = 0;
    end
    if (issue_en && f >= 0) begin
      nxt[f].v = 1; nxt[f].op = issue_op; nxt[f].rob = issue_rob;
      nxt[f].qj = issue_qj; nxt[f].qk = issue_qk;
      nxt[f].vj = issue_vj; nxt[f].jb = issue_qj_busy;
      nxt[f].vk = issue_vk; nxt[f].kb = issue_qk_busy;
      if (issue_qj_busy && cdb_lookup(issue_qj, bv)) begin nxt[f].vj = bv; nxt[f].jb = 0; end
      if (issue_qk_busy && cdb_lookup(issue_qk, bv)) begin nxt[f].vk = bv; nxt[f].kb = 0; end
    end
    m = nxt;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1; clear = 0; issue_en = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = 0; issue_qk = 0; issue_rob = 0;
    cdb_alu_en = 0; cdb_alu_rob = 0; cdb_alu_val = 0;
    cdb_lsb_en = 0; cdb_lsb_rob = 0; cdb_lsb_val = 0;
  endtask

  task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input bit jb, input logic [3:0] qj, input bit kb, input logic [3:0] qk,
                           input logic [3:0] rob);
    issue_en = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = jb; issue_qj = qj; issue_qk_busy = kb; issue_qk = qk; issue_rob = rob;
  endtask

  task automatic test_reset();
    rst_in = 1; idle(); model_reset();
    #2;
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %0b want 0", alu_flag); end
    n_checks++; if (alu_op !== 6'd0) begin n_fail++; $display("FAIL reset_op: got %0h want 0", alu_op); end
    n_checks++; if (alu_val1 !== 32'd0) begin n_fail++; $display("FAIL reset_val1: got %0h want 0", alu_val1); end
    n_checks++; if (alu_val2 !== 32'd0) begin n_fail++; $display("FAIL reset_val2: got %0h want 0", alu_val2); end
    n_checks++; if (alu_rob !== 4'd0) begin n_fail++; $display("FAIL reset_rob: got %0h want 0", alu_rob); end
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", rs_full); end
    #1 rst_in = 0;
    cycle();
  endtask

  task automatic test_ready_issue();
    set_issue(OP_ADD, 32'd5, 32'd7, 0, 0, 0, 0, 4'd3);
    cycle(); idle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL ready_early: got %0b want 0", alu_flag); end
    cycle();
    n_checks++; if (alu_flag !== 1'b1) begin n_fail++; $display("FAIL ready_flag: got %0b want 1", alu_flag); end
    n_checks++; if (alu_op !== OP_ADD) begin n_fail++; $display("FAIL ready_op: got %0h want %0h", alu_op, OP_ADD); end
    n_checks++; if (alu_val1 !== 32'd5) begin n_fail++; $display("FAIL ready_val1: got %0h want 5", alu_val1); end
    n_checks++; if (alu_val2 !== 32'd7) begin n_fail++; $display("FAIL ready_val2: got %0h want 7", alu_val2); end
    n_checks++; if (alu_rob !== 4'd3) begin n_fail++; $display("FAIL ready_rob: got %0h want 3", alu_rob); end
    cycle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL ready_after: got %0b want 0", alu_flag); end
    n_checks++; if (alu_val1 !== 32'd5) begin n_fail++; $display("FAIL ready_hold: got %0h want 5", alu_val1); end
  endtask

  task automatic test_wakeup();
    set_issue(OP_SUB, 32'd0, 32'd1, 1, 4'd9, 0, 0, 4'd4);
    cycle(); idle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL wake_wait1: got %0b want 0", alu_flag); end
    for (int c = 2; c <= 4; c++) begin
      cycle();
      n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL wake_wait%0d: got %0b want 0", c, alu_flag); end
    end
    cdb_lsb_en = 1; cdb_lsb_rob = 4'd9; cdb_lsb_val = 32'h10;
    cycle(); idle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL wake_c5: got %0b want 0", alu_flag); end
    cycle();
    n_checks++; if (alu_flag !== 1'b1) begin n_fail++; $display("FAIL wake_flag: got %0b want 1", alu_flag); end
    n_checks++; if (alu_val1 !== 32'h10) begin n_fail++; $display("FAIL wake_val1: got %0h want 10", alu_val1); end
    n_checks++; if (alu_val2 !== 32'd1) begin n_fail++; $display("FAIL wake_val2: got %0h want 1", alu_val2); end
    n_checks++; if (alu_rob !== 4'd4) begin n_fail++; $display("FAIL wake_rob: got %0h want 4", alu_rob); end
    cycle();
  endtask

  task automatic test_bypass();
    set_issue(OP_OR, 32'd3, 32'd0, 0, 0, 1, 4'd2, 4'd6);
    cdb_alu_en = 1; cdb_alu_rob = 4'd2; cdb_alu_val = 32'hFFFF_FFFF;
    cycle(); idle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL byp_early: got %0b want 0", alu_flag); end
    cycle();
    n_checks++; if (alu_flag !== 1'b1) begin n_fail++; $display("FAIL byp_flag: got %0b want 1", alu_flag); end
    n_checks++; if (alu_val2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL byp_val2: got %0h want ffffffff", alu_val2); end
    n_checks++; if (alu_val1 !== 32'd3) begin n_fail++; $display("FAIL byp_val1: got %0h want 3", alu_val1); end
    n_checks++; if (alu_rob !== 4'd6) begin n_fail++; $display("FAIL byp_rob: got %0h want 6", alu_rob); end
    cycle();
  endtask

  task automatic test_full_order();
    for (int k = 0; k < 16; k++) begin
      set_issue(OP_ADD, 32'h100 + k, 32'(k), 1, 4'd5, 0, 0, 4'(k));
      cycle();
    end
    idle();
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0b want 1", rs_full); end
    set_issue(OP_SUB, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 4'hF);
    cycle(); idle();
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %0b want 1", rs_full); end
    cdb_alu_en = 1; cdb_alu_rob = 4'd5; cdb_alu_val = 32'h55;
    cycle(); idle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL full_nodisp: got %0b want 0", alu_flag); end
    for (int k = 0; k < 16; k++) begin
      cycle();
      n_checks++; if (alu_flag !== 1'b1) begin n_fail++; $display("FAIL order_flag%0d: got %0b want 1", k, alu_flag); end
      n_checks++; if (alu_rob !== 4'(k)) begin n_fail++; $display("FAIL order_rob%0d: got %0h want %0h", k, alu_rob, k); end
      n_checks++; if (alu_val2 !== 32'(k)) begin n_fail++; $display("FAIL order_val2%0d: got %0h want %0h", k, alu_val2, k); end
      n_checks++; if (alu_val1 !== 32'h55) begin n_fail++; $display("FAIL order_val1%0d: got %0h want 55", k, alu_val1); end
      if (k == 0) begin
        n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_drop_after: got %0b want 0", rs_full); end
      end
    end
    cycle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL order_end: got %0b want 0", alu_flag); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      set_issue(OP_ADD, 32'(k + 1), 32'd0, 1, 4'd7, 0, 0, 4'(k));
      cycle();
    end
    idle();
    cdb_lsb_en = 1; cdb_lsb_rob = 4'd7; cdb_lsb_val = 32'h77;
    cycle(); idle();
    set_issue(OP_ADD, 32'd9, 32'd9, 0, 0, 0, 0, 4'd9);
    clear = 1;
    cycle(); idle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL flush_flag: got %0b want 0", alu_flag); end
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %0b want 0", rs_full); end
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL flush_quiet%0d: got %0b want 0", c, alu_flag); end
    end
  endtask

  task automatic test_async_reset();
    set_issue(OP_ADD, 32'hA, 32'hB, 0, 0, 0, 0, 4'd1);
    cycle();
    set_issue(OP_ADD, 32'hC, 32'hD, 0, 0, 0, 0, 4'd2);
    cycle(); idle();
    n_checks++; if (alu_flag !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %0b want 1", alu_flag); end
    #2 rst_in = 1;
    #1;
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL arst_flag: got %0b want 0", alu_flag); end
    n_checks++; if (alu_val1 !== 32'd0) begin n_fail++; $display("FAIL arst_val1: got %0h want 0", alu_val1); end
    #1 rst_in = 0;
    model_reset();
    cycle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL arst_wiped: got %0b want 0", alu_flag); end
  endtask

  task automatic test_stall();
    set_issue(OP_ADD, 32'h11, 32'h22, 0, 0, 0, 0, 4'd9);
    cycle(); idle();
    rdy_in = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL stall_flag%0d: got %0b want 0", c, alu_flag); end
    end
    rdy_in = 1;
    cycle();
    n_checks++; if (alu_flag !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got %0b want 1", alu_flag); end
    n_checks++; if (alu_val1 !== 32'h11) begin n_fail++; $display("FAIL stall_val1: got %0h want 11", alu_val1); end
    n_checks++; if (alu_rob !== 4'd9) begin n_fail++; $display("FAIL stall_rob: got %0h want 9", alu_rob); end
    cycle();
    n_checks++; if (alu_flag !== 1'b0) begin n_fail++; $display("FAIL stall_after: got %0b want 0", alu_flag); end
  endtask

  task automatic test_random();
    idle();
    rst_in = 1; model_reset();
    #2 rst_in = 0;
    for (int c = 0; c < 800; c++) begin
      rdy_in        = ($urandom_range(9) != 0);
      clear         = ($urandom_range(49) == 0);
      issue_en      = ($urandom_range(2) != 0);
      issue_op      = 6'($urandom_range(63));
      issue_vj      = $urandom;
      issue_vk      = $urandom;
      issue_qj_busy = ($urandom_range(1) == 0);
      issue_qk_busy = ($urandom_range(1) == 0);
      issue_qj      = 4'($urandom_range(15));
      issue_qk      = 4'($urandom_range(15));
      issue_rob     = 4'($urandom_range(15));
      cdb_alu_en    = rdy_in && ($urandom_range(2) == 0);
      cdb_lsb_en    = rdy_in && ($urandom_range(2) == 0);
      cdb_alu_rob   = 4'($urandom_range(15));
      cdb_lsb_rob   = 4'($urandom_range(15));
      if (cdb_lsb_rob == cdb_alu_rob) cdb_lsb_rob = cdb_alu_rob ^ 4'd1;
      cdb_alu_val   = $urandom;
      cdb_lsb_val   = $urandom;
      cycle();
      n_checks++; if (alu_flag !== e_flag) begin n_fail++; $display("FAIL rand_flag c%0d: got %0b want %0b", c, alu_flag, e_flag); end
      n_checks++; if (alu_op !== e_op) begin n_fail++; $display("FAIL rand_op c%0d: got %0h want %0h", c, alu_op, e_op); end
      n_checks++; if (alu_val1 !== e_v1) begin n_fail++; $display("FAIL rand_val1 c%0d: got %0h want %0h", c, alu_val1, e_v1); end
      n_checks++; if (alu_val2 !== e_v2) begin n_fail++; $display("FAIL rand_val2 c%0d: got %0h want %0h", c, alu_val2, e_v2); end
      n_checks++; if (alu_rob !== e_rob) begin n_fail++; $display("FAIL rand_rob c%0d: got %0h want %0h", c, alu_rob, e_rob); end
      n_checks++; if (rs_full !== model_full()) begin n_fail++; $display("FAIL rand_full c%0d: got %0b want %0b", c, rs_full, model_full()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_bypass();
    test_full_order();
    test_flush();
    test_async_reset();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
